hazard_detection_unit: RTL and testbench
========================================

# hazard_detection_unit

Producer-side hazard control for the 5-stage pipelined CPU. It resolves the hazards that operand forwarding cannot cover: load-use dependences, taken-branch redirects and multi-cycle data-memory accesses. It drives the PC write enable, the IF/ID write enable, the ID-stage control no-op select, the IF/ID flush and a whole-pipeline freeze. It sits beside the ID stage and watches the ID, EX and MEM stage pipeline-register fields.

## Interface
Parameters:
- `REG_W`, default 5: register-index width.
- `CNT_W`, default 32: performance-counter width (used only with `HAZARD_PERF_CNT_EN`).

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `ID_RS1_i` input REG_W: rs1 of the instruction in ID.
- `ID_RS2_i` input REG_W: rs2 of the instruction in ID.
- `ID_UsesRS2_i` input 1: the ID instruction reads rs2 (R-type, store, branch).
- `ID_Branch_i` input 1: the ID instruction is a branch.
- `ID_BranchTaken_i` input 1: the ID comparator result.
- `EX_RD_i` input REG_W: rd of the instruction in EX.
- `EX_MemRead_i` input 1: the EX instruction is a load.
- `MEM_Req_i` input 1: the MEM-stage instruction is accessing data memory.
- `MEM_Ack_i` input 1: data memory completes the access this cycle.
- `PCWrite_o` output 1: PC update enable.
- `IF_ID_Write_o` output 1: IF/ID register write enable.
- `NoOp_o` output 1: zero the ID control signals entering ID/EX (bubble).
- `Flush_o` output 1: clear IF/ID on the next edge.
- `Freeze_o` output 1: hold all pipeline registers.
- `StallCnt_o` output CNT_W: stall-cycle count (macro only).
- `FlushCnt_o` output CNT_W: flush count (macro only).

## Operation
FSM states, held in a register:
- IDLE: no memory wait is in progress.
- MEM_WAIT: a memory access is outstanding.

Hazard terms:
- Load-use hazard `lu`: `EX_MemRead_i && EX_RD_i != 0 && (EX_RD_i == ID_RS1_i || (ID_UsesRS2_i && EX_RD_i == ID_RS2_i))`.
- Memory wait `mw`: `MEM_Req_i && !MEM_Ack_i`.

Priority, evaluated per cycle: freeze > load-use > flush.
- **Freeze:** when `mw` is true, or the state is MEM_WAIT and `MEM_Ack_i` is low:
  - `Freeze_o=1`, `PCWrite_o=0`, `IF_ID_Write_o=0`.
  - `NoOp_o=0`, `Flush_o=0`.
- **Load-use:** when `lu` is true and there is no freeze:
  - `PCWrite_o=0`, `IF_ID_Write_o=0`, `NoOp_o=1`.
  - `Flush_o=0`. A branch in ID waits and is re-evaluated next cycle.
- **Flush:** when `ID_Branch_i && ID_BranchTaken_i` is true and there is neither a freeze nor `lu`:
  - `Flush_o=1`, `PCWrite_o=1`, `IF_ID_Write_o=1`.
- **Otherwise:** `PCWrite_o=1`, `IF_ID_Write_o=1`, all other outputs 0.

State transitions:
- IDLE -> MEM_WAIT on `mw`.
- MEM_WAIT -> IDLE on `MEM_Ack_i`. The freeze drops combinationally in that same cycle.
- MEM_WAIT -> MEM_WAIT otherwise. `MEM_Req_i` is ignored while in MEM_WAIT.
- An ack in the same cycle as the request stays in IDLE, with zero freeze cycles.

Reset:
- The state goes to IDLE and the counters clear immediately.
- Outputs then follow the IDLE equations. With all inputs low this gives `PCWrite_o=1`, `IF_ID_Write_o=1`, all others 0.
- A reset asserted in MEM_WAIT drops the freeze asynchronously.

## Timing
- All hazard outputs are Mealy-combinational from the inputs plus the state. They have zero latency, so the stall takes effect at the next rising edge.
- A load-use stall lasts exactly one cycle. Next cycle the load has moved to MEM, `lu` is false and forwarding covers the dependence.
- A freeze lasts N cycles, where N is the number of cycles from the request until the cycle before `MEM_Ack_i`.
- If a load-use or branch condition is present during a freeze, it is acted on in the first unfrozen cycle; the inputs are held because the pipeline is frozen.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `StallCnt_o` increments on every cycle with `Freeze_o | NoOp_o`.
  - `FlushCnt_o` increments on every `Flush_o` cycle.
  - Both counters wrap modulo 2^CNT_W and clear on reset.
- Macro undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- Shared package `cpu_pkg` holds the FSM state encoding (IDLE=1'b0, MEM_WAIT=1'b1) and `REG_W`.
- Sub-module `hazard_perf_counter` holds one wrapping counter with increment enable. It is instantiated twice, only under the macro.

## Test plan
- Load-use: EX has load, `EX_RD=5`, and ID has `RS1=5` -> one cycle with `PCWrite_o=0`, `IF_ID_Write_o=0`, `NoOp_o=1`. Next cycle, with the load in MEM, all outputs return to normal.
- x0 and the rs2 qualifier:
  - `EX_RD=0` with `RS1=0` -> no stall.
  - `RS2` matches with `ID_UsesRS2_i=0` -> no stall.
- Branch: taken branch and no hazard -> `Flush_o=1` for one cycle. Taken branch plus `lu` -> `Flush_o=0` and `NoOp_o=1`; next cycle `Flush_o=1`.
- Memory wait: `MEM_Req_i=1` with `MEM_Ack_i` arriving 3 cycles later -> `Freeze_o=1` for exactly 3 cycles. The state returns to IDLE; `StallCnt_o=3` with the macro.
- Same-cycle ack: `MEM_Req_i=1`, `MEM_Ack_i=1` -> no freeze, state stays IDLE.
- Reset mid-freeze: `rst_i` goes low in MEM_WAIT -> `Freeze_o` drops with no clock edge, and the counters read 0.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Shared CPU package: hazard-unit FSM state encoding and default register-index width.
package cpu_pkg;

    localparam int REG_W = 5;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_e;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Hazard-unit bundle: ID/EX/MEM stage fields in, pipeline control and perf counts out.
// The pipeline side uses the master modport, the hazard unit uses the slave modport.
interface hazard_detection_unit_if
    import cpu_pkg::*;
#(
    parameter int REG_W = cpu_pkg::REG_W,
    parameter int CNT_W = 32
);

    logic [REG_W-1:0] ID_RS1_i;
    logic [REG_W-1:0] ID_RS2_i;
    logic             ID_UsesRS2_i;
    logic             ID_Branch_i;
    logic             ID_BranchTaken_i;
    logic [REG_W-1:0] EX_RD_i;
    logic             EX_MemRead_i;
    logic             MEM_Req_i;
    logic             MEM_Ack_i;

    logic             PCWrite_o;
    logic             IF_ID_Write_o;
    logic             NoOp_o;
    logic             Flush_o;
    logic             Freeze_o;
    logic [CNT_W-1:0] StallCnt_o;
    logic [CNT_W-1:0] FlushCnt_o;

    modport master (
        output ID_RS1_i, ID_RS2_i, ID_UsesRS2_i, ID_Branch_i, ID_BranchTaken_i,
        output EX_RD_i, EX_MemRead_i, MEM_Req_i, MEM_Ack_i,
        input  PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o, Freeze_o,
        input  StallCnt_o, FlushCnt_o
    );

    modport slave (
        input  ID_RS1_i, ID_RS2_i, ID_UsesRS2_i, ID_Branch_i, ID_BranchTaken_i,
        input  EX_RD_i, EX_MemRead_i, MEM_Req_i, MEM_Ack_i,
        output PCWrite_o, IF_ID_Write_o, NoOp_o, Flush_o, Freeze_o,
        output StallCnt_o, FlushCnt_o
    );

endinterface

// File: rtl/hazard_detection_unit_perf_counter.sv
// Free-running wrapping event counter with increment enable, cleared by async active-low reset.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    // Count one per enabled cycle; overflow simply wraps around.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit: load-use stall, taken-branch flush and memory-wait freeze.
// Optional feature macro HAZARD_PERF_CNT_EN adds stall/flush performance counters;
// without it the count outputs are tied to zero.
module hazard_detection_unit
    import cpu_pkg::*;
#(
    parameter int REG_W = cpu_pkg::REG_W,
    parameter int CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    hazard_detection_unit_if.slave hz
);

    localparam logic [REG_W-1:0] RegZero = '0;

    hazard_state_e state_q;

    logic memWait;
    logic loadUse;
    logic freeze;
    logic takenBranch;
    logic pcWrite;
    logic ifIdWrite;
    logic noOp;
    logic flush;

    // Hazard terms and prioritised control outputs (freeze > load-use > flush), all Mealy.
    always_comb begin
        memWait     = hz.MEM_Req_i && !hz.MEM_Ack_i;
        loadUse     = hz.EX_MemRead_i && (hz.EX_RD_i != RegZero) &&
                      ((hz.EX_RD_i == hz.ID_RS1_i) ||
                       (hz.ID_UsesRS2_i && (hz.EX_RD_i == hz.ID_RS2_i)));
        takenBranch = hz.ID_Branch_i && hz.ID_BranchTaken_i;
        freeze      = memWait || ((state_q == MEM_WAIT) && !hz.MEM_Ack_i);

        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
        noOp      = 1'b0;
        flush     = 1'b0;

        if (freeze) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
        end else if (loadUse) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            noOp      = 1'b1;
        end else if (takenBranch) begin
            flush     = 1'b1;
        end
    end

    // Memory-wait FSM: enter on an unacknowledged request, leave on the ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:     if (memWait)       state_q <= MEM_WAIT;
                MEM_WAIT: if (hz.MEM_Ack_i)  state_q <= IDLE;
                default:                     state_q <= IDLE;
            endcase
        end
    end

    assign hz.PCWrite_o     = pcWrite;
    assign hz.IF_ID_Write_o = ifIdWrite;
    assign hz.NoOp_o        = noOp;
    assign hz.Flush_o       = flush;
    assign hz.Freeze_o      = freeze;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (freeze | noOp),
        .count_o (stallCount)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (flush),
        .count_o (flushCount)
    );

    assign hz.StallCnt_o = stallCount;
    assign hz.FlushCnt_o = flushCount;
`else
    assign hz.StallCnt_o = {CNT_W{1'b0}};
    assign hz.FlushCnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Testbench for hazard_detection_unit: directed plan steps followed by random traffic,
// all checked against a behavioural model of the hazard rules.
module tb_hazard_detection_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // Model state: whether the pipeline was frozen last cycle, and event tallies.
    bit          modelWaiting = 1'b0;
    int unsigned modelStalls  = 0;
    int unsigned modelFlushes = 0;
    logic [4:0]  expOuts;

    hazard_detection_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    hazard_detection_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {PCWrite, IF_ID_Write, NoOp, Flush, Freeze} from the hazard rules.
    function automatic logic [4:0] modelOutputs();
        bit lu;
        bit frz;
        lu  = hz.EX_MemRead_i && (hz.EX_RD_i != 0) &&
              (hz.EX_RD_i == hz.ID_RS1_i || (hz.ID_UsesRS2_i && hz.EX_RD_i == hz.ID_RS2_i));
        frz = !hz.MEM_Ack_i && (hz.MEM_Req_i || modelWaiting);
        if (frz)                                    return 5'b00001;
        if (lu)                                     return 5'b00100;
        if (hz.ID_Branch_i && hz.ID_BranchTaken_i)  return 5'b11010;
        return 5'b11000;
    endfunction

    task automatic applyStimulus(input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                                 input logic uses2, input logic br, input logic taken,
                                 input logic [REG_W-1:0] exRd, input logic memRead,
                                 input logic req, input logic ack);
        hz.ID_RS1_i         = rs1;
        hz.ID_RS2_i         = rs2;
        hz.ID_UsesRS2_i     = uses2;
        hz.ID_Branch_i      = br;
        hz.ID_BranchTaken_i = taken;
        hz.EX_RD_i          = exRd;
        hz.EX_MemRead_i     = memRead;
        hz.MEM_Req_i        = req;
        hz.MEM_Ack_i        = ack;
    endtask

    task automatic checkOutput(input string tag);
        logic [4:0]       obs;
        logic [CNT_W-1:0] expStall;
        logic [CNT_W-1:0] expFlush;
        expOuts = modelOutputs();
        obs = {hz.PCWrite_o, hz.IF_ID_Write_o, hz.NoOp_o, hz.Flush_o, hz.Freeze_o};
        checks++;
        assert (obs === expOuts) else begin
            errors++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, expOuts);
        end
`ifdef HAZARD_PERF_CNT_EN
        expStall = CNT_W'(modelStalls);
        expFlush = CNT_W'(modelFlushes);
`else
        expStall = '0;
        expFlush = '0;
`endif
        checks++;
        assert (hz.StallCnt_o === expStall) else begin
            errors++;
            $error("FAIL %s stallcnt observed=%0d expected=%0d", tag, hz.StallCnt_o, expStall);
        end
        checks++;
        assert (hz.FlushCnt_o === expFlush) else begin
            errors++;
            $error("FAIL %s flushcnt observed=%0d expected=%0d", tag, hz.FlushCnt_o, expFlush);
        end
    endtask

    // Clock edge: a frozen cycle means the access is still outstanding next cycle.
    task automatic advance();
        @(posedge clk);
        modelWaiting = expOuts[0];
        if (expOuts[0] || expOuts[2]) modelStalls++;
        if (expOuts[1])               modelFlushes++;
        #1;
    endtask

    task automatic step(input string tag, input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                        input logic uses2, input logic br, input logic taken,
                        input logic [REG_W-1:0] exRd, input logic memRead,
                        input logic req, input logic ack);
        applyStimulus(rs1, rs2, uses2, br, taken, exRd, memRead, req, ack);
        #1;
        checkOutput(tag);
        advance();
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("reset");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use on rs1, then the load has moved on
        step("lu_rs1",      5, 0, 0, 0, 0, 5, 1, 0, 0);
        step("lu_cleared",  5, 0, 0, 0, 0, 0, 0, 0, 0);
        // x0 never stalls; rs2 only counts when used
        step("lu_x0",       0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("rs2_unused",  1, 7, 0, 0, 0, 7, 1, 0, 0);
        step("rs2_used",    1, 7, 1, 0, 0, 7, 1, 0, 0);
        // Branches
        step("br_taken",    2, 3, 1, 1, 1, 9, 0, 0, 0);
        step("br_nottaken", 2, 3, 1, 1, 0, 9, 0, 0, 0);
        step("br_lu",       4, 3, 1, 1, 1, 4, 1, 0, 0);
        step("br_after_lu", 4, 3, 1, 1, 1, 0, 0, 0, 0);
        // Memory wait of three cycles with a load-use pending behind it
        step("mw_1",        6, 0, 0, 0, 0, 6, 1, 1, 0);
        step("mw_2",        6, 0, 0, 0, 0, 6, 1, 1, 0);
        step("mw_3",        6, 0, 0, 0, 0, 6, 1, 1, 0);
        step("mw_ack",      6, 0, 0, 0, 0, 6, 1, 1, 1);
        step("mw_done",     6, 0, 0, 0, 0, 0, 0, 0, 0);
        // Same-cycle ack must not enter the wait state
        step("same_ack",    0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("same_after",  0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while waiting drops the freeze without a clock edge
        step("pre_rst",     0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("wait_hold");
        rst_n = 1'b0;
        modelWaiting = 1'b0;
        modelStalls  = 0;
        modelFlushes = 0;
        #1;
        checkOutput("rst_midfreeze");
        #1 rst_n = 1'b1;

        // Random traffic on a small register range so dependences are frequent
        for (int i = 0; i < 300; i++) begin
            step("random",
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
